ram64x12_fifo_ctrl: RTL and testbench

Single-clock first-word-fall-through FIFO controller that is the initiator for a 64x12 two-port RAM macro. It drives the RAM write port (`W_*`) and read port (`R_ADDR`, `BLK_EN`) and captures `R_DATA`. It exposes valid/ready push and pop interfaces to fabric logic. It is the standard way fabric buffers are mapped onto the RAM primitive.

---
 rtl/ram64x12_pkg.sv | 9 +
 rtl/ram64x12_out_buf.sv | 41 ++++
 rtl/ram64x12_fifo_ctrl.sv | 89 ++++++++
 tb/tb_ram64x12_fifo_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ram64x12_pkg.sv
// Shared constants and types for the 64x12 RAM FIFO controller.
package ram64x12_pkg;
  localparam int RAM_DEPTH = 64;
  localparam int RAM_AW    = 6;
  localparam int RAM_DW    = 12;
  localparam int CNT_W     = 7;

  typedef logic [RAM_DW-1:0] ram_word_t;
endpackage

// File: rtl/ram64x12_out_buf.sv
// Two-entry output buffer at the FIFO head. The head word is held in its own
// register so that rd_data and vld come straight from flops.
module ram64x12_out_buf
  import ram64x12_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  ram_word_t wr_data,
  input  logic      rd_en,
  output ram_word_t rd_data,
  output logic      vld,
  output logic [1:0] cnt
);
  ram_word_t  slot1;
  logic [1:0] cnt_nxt;

  always_comb cnt_nxt = cnt + 2'(wr_en) - 2'(rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      vld     <= 1'b0;
      rd_data <= '0;
      slot1   <= '0;
    end else begin
      cnt <= cnt_nxt;
      vld <= (cnt_nxt != 2'd0);
      if (rd_en) begin
        // A pop advances the second slot to the head; a word arriving into a
        // buffer that is about to go empty goes straight to the head instead.
        if (wr_en && cnt == 2'd1) rd_data <= wr_data;
        else                      rd_data <= slot1;
        if (wr_en && cnt == 2'd2) slot1 <= wr_data;
      end else if (wr_en) begin
        if (cnt == 2'd0) rd_data <= wr_data;
        else             slot1   <= wr_data;
      end
    end
  end
endmodule

// File: rtl/ram64x12_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a 64x12 two-port RAM macro.
// Optional macro RAM64X12_FIFO_BUSY_EN: honour RAM_ACCESS_BUSY by stalling pushes and reads.
module ram64x12_fifo_ctrl
  import ram64x12_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int WIDTH = RAM_DW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [WIDTH-1:0]  OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CNT_W-1:0]  COUNT,
  output logic [RAM_AW-1:0] RAM_W_ADDR,
  output logic [WIDTH-1:0]  RAM_W_DATA,
  output logic              RAM_W_EN,
  output logic [RAM_AW-1:0] RAM_R_ADDR,
  output logic              RAM_BLK_EN,
  input  logic [WIDTH-1:0]  RAM_R_DATA,
  input  logic              RAM_ACCESS_BUSY
);
  logic [RAM_AW-1:0] wp;
  logic [RAM_AW-1:0] rp;
  logic [CNT_W-1:0]  ram_cnt;
  logic [CNT_W-1:0]  count_q;
  logic              inflight;
  logic [1:0]        out_cnt;
  logic              busy;
  logic              push;
  logic              pop;
  logic              issue;

`ifdef RAM64X12_FIFO_BUSY_EN
  assign busy = RAM_ACCESS_BUSY;
`else
  logic busy_unused;
  assign busy_unused = RAM_ACCESS_BUSY;
  assign busy        = 1'b0;
`endif

  assign IN_READY = !RST && !busy && (count_q < CNT_W'(DEPTH));
  assign push     = IN_VALID && IN_READY;
  assign pop      = OUT_VALID && OUT_READY;

  // Prefetch while the buffer, counting the word already on its way, still
  // has room after this cycle's pop.
  assign issue = !RST && !busy && (ram_cnt != '0) &&
                 (({1'b0, out_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign RAM_W_EN   = push;
  assign RAM_W_ADDR = wp;
  assign RAM_W_DATA = IN_DATA;
  assign RAM_BLK_EN = issue;
  assign RAM_R_ADDR = rp;
  assign COUNT      = count_q;

  // Stage p0 -> p1: read issue to RAM data return
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp       <= '0;
      rp       <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push)  wp <= wp + 1'b1;
      if (issue) rp <= rp + 1'b1;
      ram_cnt  <= ram_cnt + CNT_W'(push) - CNT_W'(issue);
      inflight <= issue;
      count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Stage p1 -> out: returned word lands in the output buffer
  ram64x12_out_buf u_out_buf (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (inflight),
    .wr_data (RAM_R_DATA),
    .rd_en   (pop),
    .rd_data (OUT_DATA),
    .vld     (OUT_VALID),
    .cnt     (out_cnt)
  );
endmodule

// File: tb/tb_ram64x12_fifo_ctrl.sv
// Self-checking bench for ram64x12_fifo_ctrl with a behavioural RAM macro and a queue-based FIFO model.
module tb_ram64x12_fifo_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] IN_DATA = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [11:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [6:0]  COUNT;
  logic [5:0]  RAM_W_ADDR;
  logic [11:0] RAM_W_DATA;
  logic        RAM_W_EN;
  logic [5:0]  RAM_R_ADDR;
  logic        RAM_BLK_EN;
  logic [11:0] RAM_R_DATA;
  logic        RAM_ACCESS_BUSY = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [11:0] mq[$];
  int          tq[$];
  logic [11:0] mem [64];

  always #5 CLK = ~CLK;

  ram64x12_fifo_ctrl dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .COUNT(COUNT),
    .RAM_W_ADDR(RAM_W_ADDR), .RAM_W_DATA(RAM_W_DATA), .RAM_W_EN(RAM_W_EN),
    .RAM_R_ADDR(RAM_R_ADDR), .RAM_BLK_EN(RAM_BLK_EN), .RAM_R_DATA(RAM_R_DATA),
    .RAM_ACCESS_BUSY(RAM_ACCESS_BUSY)
  );

  // RAM macro: registered read, data available the cycle after the read is issued
  always @(posedge CLK) begin
    if (RAM_W_EN)   mem[RAM_W_ADDR] <= RAM_W_DATA;
    if (RAM_BLK_EN) RAM_R_DATA <= mem[RAM_R_ADDR];
  end

  // A word becomes visible at the head two clock edges after the edge that wrote it.
  function automatic logic exp_valid();
    return (mq.size() > 0) && (cyc - tq[0] >= 2);
  endfunction

  task automatic drive(input logic iv, input logic [11:0] id, input logic ordy, input logic rst);
    IN_VALID = iv; IN_DATA = id; OUT_READY = ordy; RST = rst;
    #1;
  endtask

  // Advance one clock; 'vis' is the model's view of whether the head can be popped.
  task automatic tick(input logic vis);
    logic pa, pp, bsy;
    bsy = 1'b0;
`ifdef RAM64X12_FIFO_BUSY_EN
    bsy = RAM_ACCESS_BUSY;
`endif
    pa = IN_VALID && !RST && !bsy && (mq.size() < 64);
    pp = OUT_READY && vis && !RST;
    @(posedge CLK);
    cyc++;
    if (RST) begin
      mq.delete(); tq.delete();
    end else begin
      if (pp) begin void'(mq.pop_front()); void'(tq.pop_front()); end
      if (pa) begin mq.push_back(IN_DATA); tq.push_back(cyc); end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 12'h0, 0, 1); tick(0); tick(0);
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", OUT_VALID); end
    checks++; if (COUNT !== 7'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", COUNT); end
    checks++; if (OUT_DATA !== 12'h0) begin errors++; $display("FAIL rst_out_data: got %h want 000", OUT_DATA); end
    checks++; if ({RAM_W_EN, RAM_BLK_EN} !== 2'b00) begin errors++; $display("FAIL rst_ram_en: got %b want 00", {RAM_W_EN, RAM_BLK_EN}); end
    checks++; if ({RAM_W_ADDR, RAM_R_ADDR} !== 12'h0) begin errors++; $display("FAIL rst_ram_addr: got %h want 000", {RAM_W_ADDR, RAM_R_ADDR}); end
    drive(0, 12'h0, 0, 0);
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", IN_READY); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 64; i++) begin
      drive(1, 12'(i), 0, 0);
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, IN_READY); end
      tick(exp_valid());
      checks++; if (COUNT !== 7'(mq.size())) begin errors++; $display("FAIL fill_count_%0d: got %0d want %0d", i, COUNT, mq.size()); end
    end
    drive(0, 12'h0, 0, 0);
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", IN_READY); end
    checks++; if (COUNT !== 7'd64) begin errors++; $display("FAIL full_count: got %0d want 64", COUNT); end
    checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 12'h001) begin errors++; $display("FAIL full_head: got %b/%h want 1/001", OUT_VALID, OUT_DATA); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 64; i++) begin
      drive(0, 12'h0, 1, 0);
      checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 12'(i + 1)) begin errors++; $display("FAIL drain_%0d: got %b/%h want 1/%h", i, OUT_VALID, OUT_DATA, 12'(i + 1)); end
      tick(exp_valid());
    end
    checks++; if (OUT_VALID !== 1'b0 || COUNT !== 7'd0) begin errors++; $display("FAIL drain_empty: got %b/%0d want 0/0", OUT_VALID, COUNT); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 64; i++) begin drive(1, 12'($urandom_range(0, 4095)), 0, 0); tick(exp_valid()); end
    drive(1, 12'h555, 1, 0);
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL fullpop_ready_same: got %b want 0", IN_READY); end
    tick(exp_valid());
    checks++; if (COUNT !== 7'd63 || IN_READY !== 1'b1) begin errors++; $display("FAIL fullpop_after: got %0d/%b want 63/1", COUNT, IN_READY); end
    checks++; if (OUT_DATA !== mq[0]) begin errors++; $display("FAIL fullpop_head: got %h want %h", OUT_DATA, mq[0]); end
  endtask

  task automatic test_latency();
    drive(0, 12'h0, 1, 1); tick(0);
    drive(1, 12'hABC, 1, 0);
    checks++; if ({RAM_W_EN, RAM_W_ADDR, RAM_W_DATA} !== {1'b1, 6'd0, 12'hABC}) begin errors++; $display("FAIL lat_write: got %b/%0d/%h want 1/0/abc", RAM_W_EN, RAM_W_ADDR, RAM_W_DATA); end
    tick(exp_valid());
    drive(0, 12'h0, 1, 0);
    checks++; if (RAM_BLK_EN !== 1'b1 || RAM_R_ADDR !== 6'd0) begin errors++; $display("FAIL lat_issue: got %b/%0d want 1/0", RAM_BLK_EN, RAM_R_ADDR); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL lat_early1: got %b want 0", OUT_VALID); end
    tick(exp_valid());
    checks++; if (OUT_VALID !== 1'b0 || COUNT !== 7'd1) begin errors++; $display("FAIL lat_early2: got %b/%0d want 0/1", OUT_VALID, COUNT); end
    tick(exp_valid());
    checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 12'hABC) begin errors++; $display("FAIL lat_out: got %b/%h want 1/abc", OUT_VALID, OUT_DATA); end
    tick(exp_valid());
    checks++; if (OUT_VALID !== 1'b0 || COUNT !== 7'd0) begin errors++; $display("FAIL lat_popped: got %b/%0d want 0/0", OUT_VALID, COUNT); end
  endtask

  task automatic test_stream();
    int wraps = 0;
    int primed = -1;
    logic [5:0] prev_wa = '0;
    drive(0, 12'h0, 0, 1); tick(0);
    for (int i = 0; i < 200; i++) begin
      drive(1, 12'($urandom_range(0, 4095)), 1, 0);
      if (i > 0 && prev_wa == 6'd63 && RAM_W_ADDR == 6'd0) wraps++;
      prev_wa = RAM_W_ADDR;
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %b want 1", i, IN_READY); end
      tick(exp_valid());
      checks++; if (COUNT !== 7'(mq.size())) begin errors++; $display("FAIL stream_count_%0d: got %0d want %0d", i, COUNT, mq.size()); end
      checks++; if (OUT_VALID !== exp_valid()) begin errors++; $display("FAIL stream_valid_%0d: got %b want %b", i, OUT_VALID, exp_valid()); end
      if (exp_valid()) begin
        checks++; if (OUT_DATA !== mq[0]) begin errors++; $display("FAIL stream_data_%0d: got %h want %h", i, OUT_DATA, mq[0]); end
      end
      if (i == 3) primed = int'(COUNT);
      if (i > 3) begin
        checks++; if (int'(COUNT) != primed || OUT_VALID !== 1'b1) begin errors++; $display("FAIL stream_steady_%0d: got %0d/%b want %0d/1", i, COUNT, OUT_VALID, primed); end
      end
    end
    checks++; if (wraps < 3) begin errors++; $display("FAIL stream_wraps: got %0d want >=3", wraps); end
  endtask

  task automatic test_reset_mid();
    drive(0, 12'h0, 0, 1); tick(0);
    for (int k = 0; k < 5; k++) begin drive(1, 12'($urandom_range(0, 4095)), 0, 0); tick(exp_valid()); end
    drive(0, 12'h0, 1, 0);
    checks++; if (RAM_BLK_EN !== 1'b1) begin errors++; $display("FAIL mid_issue: got %b want 1", RAM_BLK_EN); end
    tick(exp_valid());
    drive(0, 12'h0, 0, 1); tick(0);
    checks++; if (COUNT !== 7'd0 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_reset: got %0d/%b want 0/0", COUNT, OUT_VALID); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 12'h0, 1, 0); tick(0);
      checks++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 12'h0 || COUNT !== 7'd0 || RAM_BLK_EN !== 1'b0) begin errors++; $display("FAIL mid_stale_%0d: got %b/%h/%0d want 0/000/0", k, OUT_VALID, OUT_DATA, COUNT); end
    end
  endtask

`ifdef RAM64X12_FIFO_BUSY_EN
  task automatic test_busy();
    drive(0, 12'h0, 0, 1); tick(0);
    for (int k = 0; k < 10; k++) begin drive(1, 12'(k + 16), 0, 0); tick(exp_valid()); end
    drive(0, 12'h0, 0, 0); tick(exp_valid()); tick(exp_valid());
    RAM_ACCESS_BUSY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1, 12'h777, 1, 0);
      checks++; if (IN_READY !== 1'b0 || RAM_BLK_EN !== 1'b0) begin errors++; $display("FAIL busy_stall_%0d: got %b/%b want 0/0", k, IN_READY, RAM_BLK_EN); end
      checks++; if (OUT_VALID !== (k < 2)) begin errors++; $display("FAIL busy_drain_%0d: got %b want %b", k, OUT_VALID, (k < 2)); end
      if (k < 2) begin
        checks++; if (OUT_DATA !== mq[0]) begin errors++; $display("FAIL busy_data_%0d: got %h want %h", k, OUT_DATA, mq[0]); end
      end
      tick(k < 2);
    end
    RAM_ACCESS_BUSY = 1'b0;
    drive(0, 12'h0, 1, 0);
    checks++; if (RAM_BLK_EN !== 1'b1 || COUNT !== 7'd8) begin errors++; $display("FAIL busy_resume: got %b/%0d want 1/8", RAM_BLK_EN, COUNT); end
    tick(1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_pop();
    test_latency();
    test_stream();
    test_reset_mid();
`ifdef RAM64X12_FIFO_BUSY_EN
    test_busy();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
